// File: rtl/max_tracker.sv
// max_tracker: running signed maximum of a streamed score matrix with its position.
// Optional macro SW_TRACK_POS_EN enables row/col position tracking.
`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

module max_tracker (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  newLine_in,
  input  logic                  last_in,
  input  logic [`V_E_F_Bit-1:0] v_in,
  input  logic                  clear_in,
  input  logic                  result_ready,
  output logic                  result_valid,
  output logic [`V_E_F_Bit-1:0] max_score,
  output logic [15:0]           max_row,
  output logic [15:0]           max_col,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic signed [`V_E_F_Bit-1:0] maxQ;
  logic start;
  logic take;
  logic better;
  logic flush;

  assign start  = (state == IDLE) && valid_in && newLine_in;
  assign take   = start || ((state == RUN) && valid_in);
  assign better = $signed(v_in) > maxQ;
  // result_valid is always high in DONE, so ready alone completes the transfer
  assign flush  = clear_in || ((state == DONE) && result_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      maxQ         <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      maxQ         <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            state        <= last_in ? DONE : RUN;
            result_valid <= last_in;
          end
        end
        RUN: begin
          if (valid_in && last_in) begin
            state        <= DONE;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (take && better) begin
        maxQ <= $signed(v_in);
      end
    end
  end

  assign max_score = maxQ;

`ifdef SW_TRACK_POS_EN
  logic [15:0] rowCnt;
  logic [15:0] colCnt;
  logic [15:0] rowNext;
  logic [15:0] colNext;
  logic [15:0] maxRowQ;
  logic [15:0] maxColQ;

  // Position of the cell currently presented, saturating at 16'hFFFF
  always_comb begin
    rowNext = rowCnt;
    colNext = colCnt;
    if (start) begin
      rowNext = '0;
      colNext = '0;
    end else if (newLine_in) begin
      rowNext = (rowCnt == 16'hFFFF) ? rowCnt : rowCnt + 16'd1;
      colNext = '0;
    end else begin
      colNext = (colCnt == 16'hFFFF) ? colCnt : colCnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rowCnt  <= '0;
      colCnt  <= '0;
      maxRowQ <= '0;
      maxColQ <= '0;
    end else if (flush) begin
      rowCnt  <= '0;
      colCnt  <= '0;
      maxRowQ <= '0;
      maxColQ <= '0;
    end else if (take) begin
      rowCnt <= rowNext;
      colCnt <= colNext;
      if (better) begin
        maxRowQ <= rowNext;
        maxColQ <= colNext;
      end
    end
  end

  assign max_row = maxRowQ;
  assign max_col = maxColQ;
`else
  assign max_row = '0;
  assign max_col = '0;
`endif

endmodule

// File: doc/max_tracker.md
MAX_TRACKER -- requirements
Module: max_tracker

Interface
REQ-001 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have valid_in  input  1  cell score on v_in valid this cycle (from last PE of the array).
REQ-004 SHALL have newLine_in  input  1  qualified by valid_in; cell is column 0 of a new row.
REQ-005 SHALL have last_in  input  1  qualified by valid_in; cell is the final cell of the matrix.
REQ-006 SHALL have v_in  input  `V_E_F_Bit  cell score, two's complement.
REQ-007 SHALL have clear_in  input  1  synchronous abort to IDLE.
REQ-008 SHALL have result_ready  input  1  consumer accepts result.
REQ-009 SHALL have result_valid  output  1  result held stable while high.
REQ-010 SHALL have max_score  output  `V_E_F_Bit  best score of the completed matrix.
REQ-011 SHALL have max_row, max_col  output  16 each  position of max_score.
REQ-012 SHALL have busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE.
REQ-014 IDLE->RUN SHALL occur on valid_in&newLine_in; that cell is row 0, col 0 and is evaluated; other IDLE input is dropped.
REQ-015 In RUN, each valid_in cell SHALL advance col by 1; valid_in&newLine_in SHALL advance row by 1 and set col to 0.
REQ-016 row and col SHALL saturate at 16'hFFFF, no wrap.
REQ-017 Running max SHALL start at 0; a cell updates max, and with position, only if v_in signed-greater than current max; ties keep the earliest cell; negative scores never update.
REQ-018 valid_in&last_in in RUN SHALL evaluate that cell, then enter DONE the next cycle with result_valid=1, i.e. 1-cycle latency from last cell.
REQ-019 In DONE, result_valid and all result outputs SHALL hold until result_valid&result_ready; the transfer cycle returns to IDLE and clears max, row, col.
REQ-020 valid_in in DONE SHALL be ignored.
REQ-021 A single cell with newLine_in and last_in in IDLE SHALL produce DONE with that cell as the result.
REQ-022 clear_in SHALL override every other input in any state: next state IDLE, max/row/col cleared, result_valid=0.
REQ-023 result outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 rst low SHALL force asynchronously: state IDLE, result_valid=0, busy=0, max_score=0, max_row=0, max_col=0, internal counters 0.
REQ-025 Reset asserted mid-RUN or mid-DONE SHALL discard the partial result; after release, the next accepted cell only follows REQ-014.

Configuration
REQ-026 Macro SW_TRACK_POS_EN SHALL control position tracking.
REQ-027 With SW_TRACK_POS_EN defined, row/col counters exist and max_row/max_col follow REQ-015..REQ-017.
REQ-028 Without SW_TRACK_POS_EN, counters SHALL be removed, max_row/max_col tied to 0, and score and handshake behaviour unchanged.

Verification
REQ-029 2x3 matrix, scores row0 {3,7,2}, row1 {7,1,5}, last on final cell -> result_valid the next cycle, max_score=7, max_row=0, max_col=1, because the tie keeps the earliest.
REQ-030 All-negative scores {-4,-1} -> max_score=0, max_row=0, max_col=0.
REQ-031 result_ready held low 10 cycles in DONE while valid_in pulses with score 50 -> outputs unchanged; ready high 1 cycle -> IDLE next cycle, busy=0.
REQ-032 Single cell 9 with newLine_in=last_in=1 from IDLE -> DONE, max_score=9 at (0,0).
REQ-033 clear_in mid-RUN after score 20, then new matrix with max 4 -> result max_score=4; repeat with rst low mid-RUN -> same.
REQ-034 Build without SW_TRACK_POS_EN, rerun REQ-029 -> max_score=7, max_row=max_col=0, identical handshake timing.
